// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - run-controlled serial pattern detector with match counter and threshold halt (optional IRQ via SEQ_DET_IRQ_EN)
module seq_det_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_wr,
    input  logic [4:0]       cfg_pat,
    input  logic [2:0]       cfg_len,
    input  logic [CNT_W-1:0] cfg_thr,
    input  logic             start,
    input  logic             stop,
    input  logic             x,
    input  logic             x_valid,
    input  logic             irq_ack,
    output logic             match,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state_q;
    logic [4:0]       pat_q;
    logic [2:0]       len_q;
    logic [CNT_W-1:0] thr_q;
    // Only the four most recent bits can take part in a match, so older history is not kept.
    logic [3:0]       hist_q;
    logic [2:0]       fill_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [2:0]       len_d;
    logic [4:0]       len_mask;
    logic [4:0]       window;
    logic             irq_q;

    // Clamp the written length into 1..5 and derive the comparison mask for the stored length.
    always_comb begin
        len_d = cfg_len;
        if (cfg_len == 3'd0) begin
            len_d = 3'd1;
        end else if (cfg_len > 3'd5) begin
            len_d = 3'd5;
        end
        len_mask = 5'((6'd1 << len_q) - 6'd1);
        window   = {hist_q, x};
    end

    // Mealy match: current bit plus history against the pattern, once enough bits have arrived.
    always_comb begin
        match = (state_q == RUN) && x_valid &&
                (((window ^ pat_q) & len_mask) == 5'd0) &&
                (fill_q >= (len_q - 3'd1));
        count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;
    end

    // Run-control FSM together with configuration, history, fill count, match count and irq.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= 5'b11011;
            len_q   <= 3'd5;
            thr_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_wr) begin
                        pat_q <= cfg_pat;
                        len_q <= len_d;
                        thr_q <= cfg_thr;
                    end
                    if (start && !stop) begin
                        state_q <= RUN;
                        hist_q  <= '0;
                        fill_q  <= '0;
                        count_q <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= IDLE;
                        irq_q   <= 1'b0;
                    end else if (x_valid) begin
                        hist_q <= {hist_q[2:0], x};
                        if (fill_q != 3'd5) begin
                            fill_q <= fill_q + 3'd1;
                        end
                        if (match) begin
                            count_q <= count_d;
                            if ((thr_q != '0) && (count_d == thr_q)) begin
                                state_q <= HALT;
`ifdef SEQ_DET_IRQ_EN
                                irq_q   <= 1'b1;
`endif
                            end
                        end
                    end
                end
                HALT: begin
                    if (stop) begin
                        state_q <= IDLE;
                        irq_q   <= 1'b0;
                    end
`ifdef SEQ_DET_IRQ_EN
                    else if (irq_ack) begin
                        state_q <= RUN;
                        count_q <= '0;
                        hist_q  <= '0;
                        fill_q  <= '0;
                        irq_q   <= 1'b0;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy  = (state_q != IDLE);
    assign count = count_q;

`ifdef SEQ_DET_IRQ_EN
    assign irq = irq_q;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack ^ irq_q;
    assign irq = 1'b0;
`endif

endmodule
